pll_reset_sequencer: RTL

//  Drives the PLL reset input and consumes the PLL locked output.

---
 rtl/pll_seq_pkg.sv | 19 +
 rtl/sync_2ff.sv | 19 +
 rtl/pll_reset_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and counter sizing shared by the PLL reset sequencer
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Width that can hold the largest of the three cycle parameters.
  function automatic int clog2max(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop bit synchroniser with asynchronous active-low clear
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  // Shift the asynchronous input through two flops before it is used.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= '0;
    else ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses PLL reset, qualifies lock, then releases the system reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRY_W        = 8
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               soft_rst,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               lock_lost,
  output logic               timeout,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [1:0]         state
);

  localparam int CW = clog2max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(STABLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, sys_rst_n_q, lock_lost_q, lock_lost_d, timeout_q, timeout_d;
  logic               locked_s, clr;

  sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (locked),
    .q_o    (locked_s)
  );

  // Next state and pulses; soft reset overrides every other transition.
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    timeout_d   = 1'b0;
    if (soft_rst) state_d = RESET_PLL;
    else case (state_q)
      RESET_PLL: state_d = cnt_q == RST_LAST ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: begin
        if (locked_s) state_d = STABLE;
        else if (cnt_q == TO_LAST) begin
          state_d   = RESET_PLL;
          timeout_d = 1'b1;
          retry_d   = &retry_q ? retry_q : retry_q + 1'b1;
        end
      end
      STABLE:  state_d = !locked_s ? WAIT_LOCK : cnt_q == ST_LAST ? RUN : STABLE;
      default: begin
        state_d     = locked_s ? RUN : RESET_PLL;
        lock_lost_d = !locked_s;
      end
    endcase
    clr = soft_rst || state_d != state_q;
  end

  // State, shared counter and outputs, all registered together with the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= clr ? '0 : cnt_q + 1'b1;
      retry_q     <= retry_d;
      pll_rst_q   <= state_d == RESET_PLL;
      sys_rst_n_q <= state_d == RUN;
      lock_lost_q <= lock_lost_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = sys_rst_n_q;
  assign lock_lost = lock_lost_q;
  assign timeout   = timeout_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
